huffman_symbol_decoder: RTL and testbench
=========================================

# huffman_symbol_decoder

Tree-walking Huffman symbol decoder sitting directly downstream of the tree builder in the PNG/DEFLATE inflate path. Once the builder reports its tree complete, it consumes the compressed stream one bit per handshake and walks the builder's 2D tree memory through the builder's read port. On reaching a leaf it emits one literal/length/distance symbol to the following LZ77 stage. Malformed codes raise a sticky error.

## Interface
- `NUMCODES`, 288: symbol alphabet size; must match the builder instance.
- `BITLENGTH`, 15: maximum code length in bits.
- `OUTWIDTH`, 10: width of a tree entry and of the output symbol.
- `AW`, derived = clogb2(2*NUMCODES-1): tree address width (10 for 288).

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `istart` in 1: synchronous clear to IDLE, including the error flag; one cycle wide.
- `tree_ready` in 1: builder `done`; tree read port valid while high.
- `tree_rdaddr` out AW: tree entry address = {treepos[AW-2:0], bit}.
- `tree_rddata` in OUTWIDTH: entry returned one cycle after `tree_rdaddr` (synchronous RAM).
- `ivalid` in 1: input bit valid.
- `ibit` in 1: next compressed bit, LSB-first order already resolved upstream.
- `iready` out 1: bit accepted on `ivalid & iready`.
- `ovalid` out 1: decoded symbol valid.
- `osymbol` out OUTWIDTH: decoded symbol.
- `oready` in 1: symbol taken on `ovalid & oready`.
- `error` out 1: sticky; set on a malformed code.

## Operation
- State registers: `state` ∈ {IDLE, FETCH, LOOKUP, OUT, ERR}; `treepos` (AW-1 bits); `depth` (clogb2(BITLENGTH+1) bits).
- **IDLE**
  - `treepos`=0, `depth`=0.
  - Moves to FETCH when `tree_ready`=1.
- **FETCH**
  - `iready`=`tree_ready`.
  - `tree_rdaddr`={treepos,ibit}, combinational.
  - On accept: `depth`+1, go to LOOKUP.
  - If `tree_ready`=0: go to IDLE.
- **LOOKUP** (`tree_rddata` valid this cycle):
  - `tree_rddata` < NUMCODES (leaf): register `osymbol`=`tree_rddata`, go to OUT.
  - Internal node, n = `tree_rddata` − NUMCODES (AW-bit subtraction):
    - If n ≥ NUMCODES−1, or `depth` = BITLENGTH: set `error`, go to ERR.
    - Otherwise `treepos`=n, go to FETCH.
  - If `tree_ready`=0 in LOOKUP: discard the partial code, go to IDLE. No symbol and no error.
- **OUT**
  - `ovalid`=1; `osymbol` stable until the handshake.
  - On `oready`: `treepos`=0, `depth`=0, go to FETCH.
  - `tree_ready` changes in OUT are ignored; the symbol is already captured.
- **ERR**
  - `iready`=0, `ovalid`=0.
  - Held until `rst` or `istart`.
- `istart` and `rst` take priority over every transition in the same cycle.
- `tree_rdaddr` is 0 outside FETCH.
- Unused upper `treepos` bits never wrap: the range check in LOOKUP precedes the assignment.

## Timing
- Reset and `istart` values:
  - `state`=IDLE, `treepos`=0, `depth`=0.
  - `iready`=0, `ovalid`=0, `osymbol`=0, `error`=0, `tree_rdaddr`=0.
- 2 cycles per code bit: FETCH accept, then LOOKUP.
- A k-bit code yields `ovalid` 2k cycles after its first bit is accepted, provided `ivalid` is continuously high.
- Minimum spacing between symbols is 2k+1 cycles: the OUT→FETCH turnaround takes one cycle when `oready`=1.
- `iready` is never high in LOOKUP, OUT or ERR.
- No combinational path from `oready` to `iready`.
- The input handshake path is combinational from `tree_ready` only.

## Test plan
- **Three-symbol tree**, entries [0]=0, [1]=289, [2]=1, [3]=2. Bits 0,1,0,1,1 with `oready`=1 → symbols 0, 1, 2 with `ovalid` at cycles 2, 7, 12 after the first accept. No `error`.
- **Backpressure:** `oready`=0 for 5 cycles after symbol 1 → `osymbol`=1 held stable, `iready`=0 throughout. Next bit accepted 1 cycle after `oready` rises.
- **Bad node:** entry [1]=288+287 → on bit 1, `error`=1 at LOOKUP+1. `iready` stays 0 until `istart`; after `istart`, `error`=0 and state is IDLE.
- **Over-long code:** BITLENGTH=15, chain of 15 internal nodes → `error` set at the 15th LOOKUP, no `ovalid`.
- **`tree_ready` drop:** deassert during LOOKUP of a 2-bit code → back to IDLE, no symbol. Reassert and feed bits 1,0 → symbol 1.
- **Reset mid-symbol:** `rst` in OUT with `ovalid`=1 → next cycle `ovalid`=0, `osymbol`=0, state IDLE.

Source files
------------

// File: rtl/huffman_symbol_decoder.sv
// ---------------------------------------------------------------------------
// huffman_symbol_decoder
//
// Walks a Huffman tree held in the tree builder's memory, one compressed bit
// per input handshake, and emits one decoded symbol per leaf reached.
// Each code bit costs two cycles: FETCH presents the tree address and accepts
// the bit, LOOKUP examines the entry returned by the synchronous RAM.
//
// Tree entry encoding: values below NUMCODES are leaves (the symbol itself);
// values NUMCODES+n point to internal node n, whose two children live at
// addresses {n, 0} and {n, 1}.
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-high reset
//   istart       synchronous clear back to IDLE (also clears error)
//   tree_ready   builder done; tree read port valid while high
//   tree_rdaddr  tree read address {treepos, ibit}, zero outside FETCH
//   tree_rddata  tree entry, one cycle after tree_rdaddr
//   ivalid/ibit  compressed input bit stream
//   iready       bit accepted on ivalid & iready
//   ovalid       decoded symbol valid
//   osymbol      decoded symbol, held until taken
//   oready       symbol taken on ovalid & oready
//   error        sticky malformed-code flag
// ---------------------------------------------------------------------------
module huffman_symbol_decoder #(
    parameter int NUMCODES  = 288,
    parameter int BITLENGTH = 15,
    parameter int OUTWIDTH  = 10,
    parameter int AW        = $clog2(2 * NUMCODES - 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                istart,
    input  logic                tree_ready,
    output logic [AW-1:0]       tree_rdaddr,
    input  logic [OUTWIDTH-1:0] tree_rddata,
    input  logic                ivalid,
    input  logic                ibit,
    output logic                iready,
    output logic                ovalid,
    output logic [OUTWIDTH-1:0] osymbol,
    input  logic                oready,
    output logic                error
);

    localparam int DW = $clog2(BITLENGTH + 1);

    localparam logic [OUTWIDTH-1:0] NC_LEAF  = OUTWIDTH'(NUMCODES);
    localparam logic [AW-1:0]       NC_BASE  = AW'(NUMCODES);
    localparam logic [AW-1:0]       NC_LIMIT = AW'(NUMCODES - 1);
    localparam logic [DW-1:0]       MAX_LEN  = DW'(BITLENGTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOOKUP,
        S_OUT,
        S_ERR
    } state_t;

    state_t              r_state;
    logic [AW-2:0]       r_treepos;
    logic [DW-1:0]       r_depth;
    logic                r_ovalid;
    logic [OUTWIDTH-1:0] r_osymbol;
    logic                r_error;

    logic                w_fetch;
    logic                w_leaf;
    logic [AW-1:0]       w_node;
    logic                w_bad;

    assign w_fetch = (r_state == S_FETCH);

    // Input handshake depends only on state and tree_ready, never on oready.
    assign iready      = w_fetch & tree_ready;
    assign tree_rdaddr = w_fetch ? {r_treepos, ibit} : '0;

    assign w_leaf = (tree_rddata < NC_LEAF);
    assign w_node = AW'(tree_rddata) - NC_BASE;

    // A child index at or beyond NUMCODES-1 cannot exist in a tree of
    // NUMCODES leaves; checking it before loading treepos keeps the
    // truncated upper bits from ever wrapping into a legal-looking node.
    assign w_bad = (w_node >= NC_LIMIT) || (r_depth == MAX_LEN);

    assign ovalid  = r_ovalid;
    assign osymbol = r_osymbol;
    assign error   = r_error;

    always_ff @(posedge clk) begin
        if (rst || istart) begin
            r_state   <= S_IDLE;
            r_treepos <= '0;
            r_depth   <= '0;
            r_ovalid  <= 1'b0;
            r_osymbol <= '0;
            r_error   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_treepos <= '0;
                    r_depth   <= '0;
                    if (tree_ready) begin
                        r_state <= S_FETCH;
                    end
                end

                S_FETCH: begin
                    if (!tree_ready) begin
                        r_state <= S_IDLE;
                    end else if (ivalid) begin
                        r_depth <= r_depth + DW'(1);
                        r_state <= S_LOOKUP;
                    end
                end

                // tree_rddata holds the entry addressed in the accept cycle.
                S_LOOKUP: begin
                    if (!tree_ready) begin
                        r_state <= S_IDLE;
                    end else if (w_leaf) begin
                        r_osymbol <= tree_rddata;
                        r_ovalid  <= 1'b1;
                        r_state   <= S_OUT;
                    end else if (w_bad) begin
                        r_error <= 1'b1;
                        r_state <= S_ERR;
                    end else begin
                        r_treepos <= w_node[AW-2:0];
                        r_state   <= S_FETCH;
                    end
                end

                // Symbol already captured, so tree_ready is not watched here.
                S_OUT: begin
                    if (oready) begin
                        r_ovalid  <= 1'b0;
                        r_treepos <= '0;
                        r_depth   <= '0;
                        r_state   <= S_FETCH;
                    end
                end

                S_ERR: begin
                    r_state <= S_ERR;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_huffman_symbol_decoder.sv
// ---------------------------------------------------------------------------
// tb_huffman_symbol_decoder
//
// Bench for huffman_symbol_decoder. A behavioural model decodes the bits
// accepted so far by walking the tree array from the root each time, and a
// compare process checks every DUT output on every falling edge. Directed
// scenarios pin the model with hand-computed values; a randomized phase then
// exercises random trees, stalls, tree_ready drops, istart and rst.
// ---------------------------------------------------------------------------
module tb_huffman_symbol_decoder;

    localparam int NUMCODES  = 288;
    localparam int BITLENGTH = 15;
    localparam int OUTWIDTH  = 10;
    localparam int AW        = 10;

    logic                clk = 1'b0;
    logic                rst;
    logic                istart;
    logic                tree_ready;
    logic [AW-1:0]       tree_rdaddr;
    logic [OUTWIDTH-1:0] tree_rddata;
    logic                ivalid;
    logic                ibit;
    logic                iready;
    logic                ovalid;
    logic [OUTWIDTH-1:0] osymbol;
    logic                oready;
    logic                error;

    huffman_symbol_decoder #(
        .NUMCODES (NUMCODES),
        .BITLENGTH(BITLENGTH),
        .OUTWIDTH (OUTWIDTH),
        .AW       (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .istart     (istart),
        .tree_ready (tree_ready),
        .tree_rdaddr(tree_rdaddr),
        .tree_rddata(tree_rddata),
        .ivalid     (ivalid),
        .ibit       (ibit),
        .iready     (iready),
        .ovalid     (ovalid),
        .osymbol    (osymbol),
        .oready     (oready),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Tree memory standing in for the builder, synchronous read.
    logic [OUTWIDTH-1:0] tree_mem [0:1023];
    always @(posedge clk) tree_rddata <= tree_mem[tree_rdaddr];

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_code holds the bits of the code in progress; the decision for a
    // code is recomputed by walking the whole tree array from the root.
    logic [15:0] m_code;
    int          m_len;
    bit          m_act;   // decoder has left IDLE
    bit          m_pend;  // a bit was accepted, its entry is being examined
    bit          m_ov;    // symbol waiting for the consumer
    bit          m_err;
    int          m_sym;

    // Returns symbol (leaf), -1 (malformed), or 1000+node (still inside tree).
    function automatic int walk(input int len);
        int node, e;
        node = 0;
        for (int i = 0; i < len; i++) begin
            e = int'(tree_mem[2 * node + int'(m_code[i])]);
            if (e < NUMCODES) return e;
            if ((e - NUMCODES >= NUMCODES - 1) || (i + 1 == BITLENGTH)) return -1;
            node = e - NUMCODES;
        end
        return 1000 + node;
    endfunction

    function automatic bit m_fetch();
        return m_act && !m_pend && !m_ov && !m_err;
    endfunction

    function automatic int exp_addr();
        if (!m_fetch()) return 0;
        return 2 * (walk(m_len) - 1000) + int'(ibit);
    endfunction

    always @(posedge clk) begin
        if (rst || istart) begin
            m_act <= 1'b0; m_pend <= 1'b0; m_ov <= 1'b0; m_err <= 1'b0;
            m_sym <= 0;    m_len <= 0;
        end else if (m_err) begin
            m_err <= 1'b1;
        end else if (m_ov) begin
            if (oready) begin
                m_ov  <= 1'b0;
                m_len <= 0;
            end
        end else if (m_pend) begin
            m_pend <= 1'b0;
            if (!tree_ready) begin
                m_act <= 1'b0;
                m_len <= 0;
            end else if (walk(m_len) < 0) begin
                m_err <= 1'b1;
            end else if (walk(m_len) < NUMCODES) begin
                m_ov  <= 1'b1;
                m_sym <= walk(m_len);
            end
        end else if (m_act) begin
            if (!tree_ready) begin
                m_act <= 1'b0;
                m_len <= 0;
            end else if (ivalid) begin
                m_code[m_len] <= ibit;
                m_len         <= m_len + 1;
                m_pend        <= 1'b1;
            end
        end else begin
            m_len <= 0;
            if (tree_ready) m_act <= 1'b1;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("iready",      iready,      m_fetch() && tree_ready);
            chk("ovalid",      ovalid,      m_ov);
            chk("osymbol",     osymbol,     m_sym);
            chk("error",       error,       m_err);
            chk("tree_rdaddr", tree_rdaddr, exp_addr());
        end
    end

    // ---------------- stimulus ----------------
    logic bits [0:63];
    int   sym_val [0:15];
    int   sym_cyc [0:15];
    int   acc_cyc [0:63];
    int   nsym, err_cyc, first_acc;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feeds n bits (ivalid held high while any remain) for ncyc cycles.
    // While symbol number bp_sym is valid, oready is held low for bp_len
    // cycles and the held symbol is checked against bp_val.
    task automatic run_seq(input int n, input int ncyc, input int bp_sym,
                           input int bp_len, input int bp_val);
        int   idx, bp_left;
        logic acc;
        idx = 0; bp_left = bp_len; nsym = 0; err_cyc = -1; first_acc = -1;
        for (int c = 0; c < ncyc; c++) begin
            ivalid = (idx < n);
            ibit   = (idx < n) ? bits[idx] : 1'b0;
            oready = !(ovalid && nsym == bp_sym && bp_left > 0);
            @(negedge clk);
            acc = ivalid && iready;
            if (acc) begin
                if (first_acc < 0) first_acc = c;
                acc_cyc[idx] = c;
            end
            if (!oready) begin
                bp_left--;
                chk("bp_osymbol_held", osymbol, bp_val);
                chk("bp_iready_low",   iready,  0);
            end
            if (ovalid && oready && nsym < 16) begin
                sym_val[nsym] = int'(osymbol);
                sym_cyc[nsym] = c - first_acc;
                nsym++;
            end
            if (error && err_cyc < 0) err_cyc = c - first_acc;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        ivalid = 1'b0;
    endtask

    task automatic load_small_tree();
        for (int a = 0; a < 1024; a++) tree_mem[a] = '0;
        tree_mem[0] = 10'd0;
        tree_mem[1] = 10'd289;
        tree_mem[2] = 10'd1;
        tree_mem[3] = 10'd2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int leaf_pct, r;
        rst = 1'b1; istart = 1'b0; tree_ready = 1'b0;
        ivalid = 1'b0; ibit = 1'b0; oready = 1'b1;
        load_small_tree();
        do_reset();
        chk_en = 1'b1;

        // Reset state
        chk("rst_iready",  iready,      0);
        chk("rst_ovalid",  ovalid,      0);
        chk("rst_osymbol", osymbol,     0);
        chk("rst_error",   error,       0);
        chk("rst_rdaddr",  tree_rdaddr, 0);

        // Three-symbol tree: codes 0 -> 0, 10 -> 1, 11 -> 2
        tree_ready = 1'b1;
        tick();
        bits[0] = 0; bits[1] = 1; bits[2] = 0; bits[3] = 1; bits[4] = 1;
        run_seq(5, 20, -1, 0, 0);
        chk("t1_nsym",  nsym, 3);
        chk("t1_sym0",  sym_val[0], 0);
        chk("t1_sym1",  sym_val[1], 1);
        chk("t1_sym2",  sym_val[2], 2);
        chk("t1_cyc0",  sym_cyc[0], 2);
        chk("t1_cyc1",  sym_cyc[1], 7);
        chk("t1_cyc2",  sym_cyc[2], 12);
        chk("t1_noerr", err_cyc,    -1);

        // Backpressure: symbol 1 held for 5 cycles
        run_seq(5, 30, 1, 5, 1);
        chk("t2_nsym",     nsym, 3);
        chk("t2_sym1",     sym_val[1], 1);
        chk("t2_sym2",     sym_val[2], 2);
        chk("t2_take1",    sym_cyc[1], 12);
        chk("t2_next_acc", acc_cyc[3] - first_acc, 13);
        chk("t2_cyc2",     sym_cyc[2], 17);

        // Bad node: entry [1] = 288 + 287
        tree_mem[1] = 10'd575;
        do_reset();
        tree_ready = 1'b1;
        tick();
        bits[0] = 1;
        run_seq(1, 6, -1, 0, 0);
        chk("t3_err_cyc", err_cyc, 2);
        chk("t3_nsym",    nsym,    0);
        ivalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t3_err_iready", iready, 0);
            chk("t3_err_sticky", error,  1);
            tick();
        end
        ivalid = 1'b0;
        istart = 1'b1;
        tick();
        istart = 1'b0;
        chk("t3_istart_err",    error,  0);
        chk("t3_istart_iready", iready, 0);
        tick();
        chk("t3_fetch_iready",  iready, 1);
        tree_mem[1] = 10'd289;

        // Over-long code: chain of 15 internal nodes on bit 0
        for (int i = 0; i < 15; i++) tree_mem[2 * i] = 10'(NUMCODES + i + 1);
        do_reset();
        tree_ready = 1'b1;
        tick();
        for (int i = 0; i < 15; i++) bits[i] = 0;
        run_seq(15, 40, -1, 0, 0);
        chk("t4_err_cyc", err_cyc, 30);
        chk("t4_nsym",    nsym,    0);

        // tree_ready drop during LOOKUP of a 2-bit code
        load_small_tree();
        do_reset();
        tree_ready = 1'b1;
        tick();
        ivalid = 1'b1; ibit = 1'b1;
        @(negedge clk);
        chk("t5_first_acc", iready, 1);
        tick();
        tree_ready = 1'b0; ivalid = 1'b0;
        tick();
        chk("t5_drop_ovalid", ovalid, 0);
        chk("t5_drop_error",  error,  0);
        tick();
        chk("t5_idle_ovalid", ovalid, 0);
        tree_ready = 1'b1;
        tick();
        bits[0] = 1; bits[1] = 0;
        run_seq(2, 8, -1, 0, 0);
        chk("t5_nsym", nsym,       1);
        chk("t5_sym",  sym_val[0], 1);
        chk("t5_cyc",  sym_cyc[0], 4);

        // Reset while a symbol is waiting
        bits[0] = 1; bits[1] = 1;
        run_seq(2, 8, 0, 100, 2);
        oready = 1'b0;
        chk("t6_pre_ovalid",  ovalid,  1);
        chk("t6_pre_osymbol", osymbol, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_ovalid",  ovalid,      0);
        chk("t6_osymbol", osymbol,     0);
        chk("t6_iready",  iready,      0);
        chk("t6_rdaddr",  tree_rdaddr, 0);
        oready = 1'b1;
        tick();
        chk("t6_fetch_iready", iready, 1);

        // Randomized phase over several random trees
        for (int blk = 0; blk < 4; blk++) begin
            leaf_pct = (blk == 0) ? 50 : (blk == 1) ? 40 : (blk == 2) ? 25 : 12;
            rst = 1'b1; istart = 1'b0; ivalid = 1'b0;
            tick();
            for (int a = 0; a < 1024; a++) begin
                r = $urandom_range(99);
                if (r < leaf_pct)
                    tree_mem[a] = 10'($urandom_range(NUMCODES - 1));
                else if (r < 96)
                    tree_mem[a] = 10'(NUMCODES + $urandom_range(11));
                else
                    tree_mem[a] = 10'($urandom_range(1023));
            end
            rst = 1'b0;
            tree_ready = 1'b1;
            for (int c = 0; c < 1500; c++) begin
                ivalid = ($urandom_range(99) < 75);
                ibit   = 1'($urandom_range(1));
                oready = ($urandom_range(99) < 70);
                if (tree_ready) tree_ready = ($urandom_range(99) >= 2);
                else            tree_ready = ($urandom_range(99) < 30);
                istart = !istart && ($urandom_range(199) == 0);
                rst    = ($urandom_range(499) == 0);
                tick();
            end
            istart = 1'b0;
            rst    = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
